// File: rtl/sobel_pkg.sv
// Shared types and byte-lane positions for the Sobel column packer.
// Column word layout: {flags[31:24], top[23:16], mid[15:8], bot[7:0]}.
package sobel_pkg;

  typedef logic [7:0]  pix_t;
  typedef logic [31:0] col_word_t;

  localparam int TOP_LSB  = 16;
  localparam int MID_LSB  = 8;
  localparam int BOT_LSB  = 0;
  localparam int FLAG_EOL = 31;
  localparam int FLAG_SOF = 30;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM,
    DONE
  } state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of 8-bit pixels: synchronous write, asynchronous read at the
// same address so a read-modify-shift happens in a single cycle.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pix_t          wdata,
  output pix_t          rdata
);

  pix_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_column_packer.sv
// Raster pixel stream -> 3-row column words for the Sobel filter.
// Build option SOBEL_PACK_FLAGS_EN adds end-of-row / first-column flags in col_out[31:30].
module sobel_column_packer
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic [7:0]  pix_in,
  input  logic        pix_sof,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [31:0] col_out,
  output logic        col_valid,
  input  logic        col_ready,
  output logic        frame_done,
  output logic        busy
);

  localparam int COL_AW = $clog2(IMG_WIDTH);
  localparam int ROW_AW = $clog2(IMG_HEIGHT);
  localparam logic [COL_AW-1:0] COL_LAST = COL_AW'(IMG_WIDTH - 1);
  localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(IMG_HEIGHT - 1);

  state_t            state, state_next;
  logic [COL_AW-1:0] col;
  logic [ROW_AW-1:0] row;
  logic              drain;
  logic              pix_accept, col_accept, sof_accept, lb_we, col_load;
  logic              at_eol, last_row;
  logic [COL_AW-1:0] lb_addr;
  pix_t              top_rd, mid_rd;
  col_word_t         col_next;

  assign pix_accept = pix_valid && pix_ready;
  assign col_accept = col_valid && col_ready;
  assign sof_accept = pix_accept && pix_sof;
  assign at_eol     = (col == COL_LAST);
  assign last_row   = (row == ROW_LAST);
  // IDLE drops pixels that do not start a frame; a SOF pixel always lands at column 0.
  assign lb_we      = pix_accept && ((state != IDLE) || pix_sof);
  assign lb_addr    = sof_accept ? '0 : col;
  assign col_load   = pix_accept && !pix_sof && (state == STREAM);

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .AW(COL_AW)) u_lb_top (
    .clk(CLOCK_50), .we(lb_we), .addr(lb_addr), .wdata(mid_rd), .rdata(top_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .AW(COL_AW)) u_lb_mid (
    .clk(CLOCK_50), .we(lb_we), .addr(lb_addr), .wdata(pix_in), .rdata(mid_rd)
  );

  always_comb begin
    col_next = '0;
    col_next[TOP_LSB +: 8] = top_rd;
    col_next[MID_LSB +: 8] = mid_rd;
    col_next[BOT_LSB +: 8] = pix_in;
`ifdef SOBEL_PACK_FLAGS_EN
    col_next[FLAG_EOL] = at_eol;
    col_next[FLAG_SOF] = (row == ROW_AW'(2)) && (col == '0);
`endif
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sof_accept) state_next = PRIME;
      PRIME: begin
        if (sof_accept) state_next = PRIME;
        else if (pix_accept && (row == ROW_AW'(1)) && at_eol) state_next = STREAM;
      end
      STREAM: begin
        if (sof_accept) state_next = PRIME;
        else if (drain && col_accept) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pix_ready  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:    pix_ready = 1'b1;
      PRIME: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
      end
      STREAM: begin
        pix_ready = !drain && (!col_valid || col_ready);
        busy      = 1'b1;
      end
      DONE: begin
        frame_done = 1'b1;
        busy       = 1'b1;
      end
      default: ;
    endcase
    if (rst) pix_ready = 1'b0;
  end

  // Row saturates on the last pixel; drain then marks the final column in flight.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      col   <= '0;
      row   <= '0;
      drain <= 1'b0;
    end else begin
      if (sof_accept) begin
        col <= COL_AW'(1);
        row <= '0;
      end else if (pix_accept && (state != IDLE)) begin
        if (at_eol) begin
          col <= '0;
          if (!last_row) row <= row + ROW_AW'(1);
        end else begin
          col <= col + COL_AW'(1);
        end
      end
      if (sof_accept)                          drain <= 1'b0;
      else if (col_load && last_row && at_eol) drain <= 1'b1;
      else if (state != STREAM)                drain <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      col_out   <= '0;
      col_valid <= 1'b0;
    end else if (col_load) begin
      col_out   <= col_next;
      col_valid <= 1'b1;
    end else if (col_accept) begin
      col_valid <= 1'b0;
    end
  end

endmodule
